// File: rtl/r2r_dac_stream_player.sv
// Streaming playback controller for the R2R ladder DAC: buffers samples in a
// small FIFO and presents one code per divided sample tick.
`timescale 1ns/1ps

module r2r_dac_stream_player #(
  parameter int unsigned       N_BITS      = 8,
  parameter int unsigned       CLK_DIV     = 100_000,
  parameter int unsigned       FIFO_DEPTH  = 16,
  parameter int unsigned       PRIME_LEVEL = 8,
  parameter logic [N_BITS-1:0] IDLE_CODE   = '0
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            enable,
  input  logic [N_BITS-1:0]               s_data,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic                            flush,
  input  logic                            clear_underrun,
  output logic [N_BITS-1:0]               dac_code,
  output logic                            playing,
  output logic                            underrun,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_PLAY  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]    level_q, level_d;
  logic [N_BITS-1:0]   dac_q, dac_d;
  logic                underrun_q, underrun_d;
  logic [N_BITS-1:0]   mem_q [FIFO_DEPTH];

  logic tick_c;
  logic fifo_empty_c;
  logic wr_c;
  logic pop_c;
  logic underrun_set_c;

  // Free-running sample-rate divider; tick marks the wrap cycle.
  always_comb begin
    tick_c = (div_q == DIV_W'(CLK_DIV - 1));
    div_d  = tick_c ? '0 : div_q + DIV_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; dropping enable overrides everything, including a tick.
  always_comb begin
    state_d      = state_q;
    fifo_empty_c = (level_q == '0);
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_PRIME;
        end
        ST_PRIME: begin
          if (level_q >= LVL_W'(PRIME_LEVEL)) begin
            state_d = ST_PRIME == state_q ? ST_PLAY : state_q;
          end
        end
        ST_PLAY: begin
          if (tick_c && fifo_empty_c) begin
            state_d = ST_PRIME;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // FSM outputs: pop/underrun decisions and the next DAC code.
  always_comb begin
    pop_c          = 1'b0;
    underrun_set_c = 1'b0;
    dac_d          = dac_q;
    if (!enable) begin
      dac_d = IDLE_CODE;
    end else if (state_q == ST_PLAY && tick_c) begin
      if (fifo_empty_c) begin
        underrun_set_c = 1'b1;
      end else if (!flush) begin
        pop_c = 1'b1;
        dac_d = mem_q[rd_ptr_q];
      end
    end
    underrun_d = underrun_set_c | (underrun_q & ~clear_underrun);
  end

  // FIFO pointer and occupancy bookkeeping; flush discards the cycle's traffic.
  always_comb begin
    wr_c     = s_valid && s_ready && !flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (wr_c) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({wr_c, pop_c})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      dac_q      <= IDLE_CODE;
      underrun_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      dac_q      <= dac_d;
      underrun_q <= underrun_d;
    end
  end

  // Sample storage needs no reset: occupancy alone defines valid entries.
  always_ff @(posedge clk) begin
    if (wr_c) begin
      mem_q[wr_ptr_q] <= s_data;
    end
  end

  assign s_ready    = (level_q < LVL_W'(FIFO_DEPTH));
  assign dac_code   = dac_q;
  assign playing    = (state_q == ST_PLAY);
  assign underrun   = underrun_q;
  assign fifo_level = level_q;

endmodule

// File: tb/tb_r2r_dac_stream_player.sv
// Self-checking bench for r2r_dac_stream_player: directed scenarios plus a
// randomized run against a queue-based reference model.
`timescale 1ns/1ps

module tb_r2r_dac_stream_player;

  localparam int unsigned N_BITS      = 8;
  localparam int unsigned CLK_DIV     = 4;
  localparam int unsigned FIFO_DEPTH  = 4;
  localparam int unsigned PRIME_LEVEL = 2;
  localparam logic [7:0]  IDLE        = 8'h00;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic       flush;
  logic       clear_underrun;
  logic [7:0] dac_code;
  logic       playing;
  logic       underrun;
  logic [2:0] fifo_level;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [7:0] m_q[$];
  int         m_mode;   // 0 idle, 1 prime, 2 play
  logic [7:0] m_dac;
  bit         m_under;
  int         m_edges;

  r2r_dac_stream_player #(
    .N_BITS(N_BITS), .CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH),
    .PRIME_LEVEL(PRIME_LEVEL), .IDLE_CODE(IDLE)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .s_data(s_data),
    .s_valid(s_valid), .s_ready(s_ready), .flush(flush),
    .clear_underrun(clear_underrun), .dac_code(dac_code), .playing(playing),
    .underrun(underrun), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clk_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Leaves the bench 1ns after a posedge with reset released; next edge is edge 1.
  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; s_valid = 1'b0; s_data = 8'h00;
    flush = 1'b0; clear_underrun = 1'b0;
    clk_n(2);
    reset = 1'b0;
  endtask

  // Advances the model by one clock using the inputs currently applied.
  task automatic model_step();
    bit tick, wr, pop, set;
    int lvl;
    tick = ((m_edges + 1) % CLK_DIV) == 0;
    lvl  = m_q.size();
    wr   = s_valid && (lvl < FIFO_DEPTH);
    pop  = 1'b0;
    set  = 1'b0;
    if (!enable) begin
      m_mode = 0;
      m_dac  = IDLE;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (lvl >= PRIME_LEVEL) m_mode = 2;
    end else if (tick) begin
      if (lvl == 0) begin
        set    = 1'b1;
        m_mode = 1;
      end else if (!flush) begin
        pop = 1'b1;
      end
    end
    if (pop) m_dac = m_q[0];
    if (set) m_under = 1'b1;
    else if (clear_underrun) m_under = 1'b0;
    if (flush) begin
      m_q.delete();
    end else begin
      if (pop) void'(m_q.pop_front());
      if (wr) m_q.push_back(s_data);
    end
    m_edges++;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (dac_code !== IDLE) begin n_fail++; $display("FAIL reset_dac dac_code=%h expected %h", dac_code, IDLE); end
    n_checks++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL reset_level fifo_level=%0d expected 0", fifo_level); end
    n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready s_ready=%b expected 1", s_ready); end
    n_checks++; if (playing !== 1'b0) begin n_fail++; $display("FAIL reset_playing playing=%b expected 0", playing); end
    n_checks++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL reset_underrun underrun=%b expected 0", underrun); end
  endtask

  task automatic test_basic();
    do_reset();
    enable = 1'b1; s_valid = 1'b1; s_data = 8'h10;
    clk_n(1);
    s_data = 8'h20;
    clk_n(1);
    s_valid = 1'b0;
    n_checks++; if (playing !== 1'b0) begin n_fail++; $display("FAIL basic_not_yet playing=%b expected 0", playing); end
    n_checks++; if (fifo_level !== 3'd2) begin n_fail++; $display("FAIL basic_level fifo_level=%0d expected 2", fifo_level); end
    clk_n(1);
    n_checks++; if (playing !== 1'b1) begin n_fail++; $display("FAIL basic_playing playing=%b expected 1", playing); end
    n_checks++; if (dac_code !== 8'h00) begin n_fail++; $display("FAIL basic_pre_tick dac_code=%h expected 00", dac_code); end
    clk_n(1);
    n_checks++; if (dac_code !== 8'h10) begin n_fail++; $display("FAIL basic_first dac_code=%h expected 10", dac_code); end
    clk_n(3);
    n_checks++; if (dac_code !== 8'h10) begin n_fail++; $display("FAIL basic_hold dac_code=%h expected 10", dac_code); end
    clk_n(1);
    n_checks++; if (dac_code !== 8'h20) begin n_fail++; $display("FAIL basic_second dac_code=%h expected 20", dac_code); end
  endtask

  task automatic test_full_fifo();
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      s_valid = 1'b1; s_data = 8'(i);
      clk_n(1);
    end
    n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready s_ready=%b expected 0", s_ready); end
    n_checks++; if (fifo_level !== 3'd4) begin n_fail++; $display("FAIL full_level fifo_level=%0d expected 4", fifo_level); end
    s_data = 8'h05;
    clk_n(1);
    n_checks++; if (fifo_level !== 3'd4) begin n_fail++; $display("FAIL full_reject fifo_level=%0d expected 4", fifo_level); end
    s_valid = 1'b0; enable = 1'b1;
    clk_n(2);
    n_checks++; if (playing !== 1'b1) begin n_fail++; $display("FAIL full_playing playing=%b expected 1", playing); end
    n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready_prepop s_ready=%b expected 0", s_ready); end
    clk_n(1);
    n_checks++; if (dac_code !== 8'h01) begin n_fail++; $display("FAIL full_code1 dac_code=%h expected 01", dac_code); end
    n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_rise s_ready=%b expected 1", s_ready); end
    for (int k = 2; k <= 4; k++) begin
      clk_n(4);
      n_checks++; if (dac_code !== 8'(k)) begin n_fail++; $display("FAIL full_code%0d dac_code=%h expected %h", k, dac_code, 8'(k)); end
    end
    clk_n(4);
    n_checks++; if (dac_code !== 8'h04) begin n_fail++; $display("FAIL full_no_05 dac_code=%h expected 04", dac_code); end
    n_checks++; if (underrun !== 1'b1) begin n_fail++; $display("FAIL full_underrun underrun=%b expected 1", underrun); end
  endtask

  task automatic test_underrun();
    do_reset();
    enable = 1'b1; s_valid = 1'b1; s_data = 8'h10;
    clk_n(1);
    s_data = 8'h20;
    clk_n(1);
    s_valid = 1'b0;
    clk_n(10);
    n_checks++; if (dac_code !== 8'h20) begin n_fail++; $display("FAIL ur_hold dac_code=%h expected 20", dac_code); end
    n_checks++; if (underrun !== 1'b1) begin n_fail++; $display("FAIL ur_set underrun=%b expected 1", underrun); end
    n_checks++; if (playing !== 1'b0) begin n_fail++; $display("FAIL ur_stop playing=%b expected 0", playing); end
    clk_n(4);
    n_checks++; if (playing !== 1'b0) begin n_fail++; $display("FAIL ur_prime playing=%b expected 0", playing); end
    s_valid = 1'b1; s_data = 8'h30;
    clk_n(1);
    s_data = 8'h40;
    clk_n(1);
    s_valid = 1'b0;
    n_checks++; if (playing !== 1'b0) begin n_fail++; $display("FAIL ur_reprime_early playing=%b expected 0", playing); end
    clk_n(1);
    n_checks++; if (playing !== 1'b1) begin n_fail++; $display("FAIL ur_reprime playing=%b expected 1", playing); end
    clk_n(1);
    n_checks++; if (dac_code !== 8'h30) begin n_fail++; $display("FAIL ur_restart dac_code=%h expected 30", dac_code); end
    n_checks++; if (underrun !== 1'b1) begin n_fail++; $display("FAIL ur_sticky underrun=%b expected 1", underrun); end
    clear_underrun = 1'b1;
    clk_n(1);
    clear_underrun = 1'b0;
    n_checks++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL ur_clear underrun=%b expected 0", underrun); end
    clk_n(3);
    n_checks++; if (dac_code !== 8'h40) begin n_fail++; $display("FAIL ur_next dac_code=%h expected 40", dac_code); end
    clk_n(3);
    clear_underrun = 1'b1;
    clk_n(1);
    clear_underrun = 1'b0;
    n_checks++; if (underrun !== 1'b1) begin n_fail++; $display("FAIL ur_set_wins underrun=%b expected 1", underrun); end
  endtask

  task automatic test_disable();
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1; s_data = 8'hA1 + 8'(i);
      clk_n(1);
    end
    s_valid = 1'b0;
    n_checks++; if (fifo_level !== 3'd3) begin n_fail++; $display("FAIL dis_wr_pop_level fifo_level=%0d expected 3", fifo_level); end
    n_checks++; if (dac_code !== 8'hA1) begin n_fail++; $display("FAIL dis_first dac_code=%h expected a1", dac_code); end
    clk_n(3);
    enable = 1'b0;
    clk_n(1);
    n_checks++; if (dac_code !== IDLE) begin n_fail++; $display("FAIL dis_idle_code dac_code=%h expected %h", dac_code, IDLE); end
    n_checks++; if (fifo_level !== 3'd3) begin n_fail++; $display("FAIL dis_no_pop fifo_level=%0d expected 3", fifo_level); end
    n_checks++; if (playing !== 1'b0) begin n_fail++; $display("FAIL dis_playing playing=%b expected 0", playing); end
    enable = 1'b1;
    clk_n(4);
    n_checks++; if (dac_code !== 8'hA2) begin n_fail++; $display("FAIL dis_resume dac_code=%h expected a2", dac_code); end
    n_checks++; if (fifo_level !== 3'd2) begin n_fail++; $display("FAIL dis_resume_level fifo_level=%0d expected 2", fifo_level); end
  endtask

  task automatic test_flush();
    do_reset();
    s_valid = 1'b1; s_data = 8'h11;
    clk_n(1);
    s_data = 8'h22;
    clk_n(1);
    s_data = 8'h33; flush = 1'b1;
    clk_n(1);
    flush = 1'b0; s_valid = 1'b0;
    n_checks++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL flush_wr_level fifo_level=%0d expected 0", fifo_level); end
    n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready s_ready=%b expected 1", s_ready); end
    enable = 1'b1; s_valid = 1'b1; s_data = 8'h44;
    clk_n(1);
    s_data = 8'h55;
    clk_n(1);
    s_valid = 1'b0;
    clk_n(3);
    n_checks++; if (dac_code !== 8'h44) begin n_fail++; $display("FAIL flush_play dac_code=%h expected 44", dac_code); end
    flush = 1'b1;
    clk_n(1);
    flush = 1'b0;
    n_checks++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL flush_play_level fifo_level=%0d expected 0", fifo_level); end
    n_checks++; if (dac_code !== 8'h44 || playing !== 1'b1) begin n_fail++; $display("FAIL flush_keep dac_code=%h playing=%b expected 44 1", dac_code, playing); end
    clk_n(3);
    n_checks++; if (underrun !== 1'b1 || dac_code !== 8'h44) begin n_fail++; $display("FAIL flush_underrun underrun=%b dac_code=%h expected 1 44", underrun, dac_code); end
    flush = 1'b1;
    clk_n(1);
    flush = 1'b0;
    n_checks++; if (underrun !== 1'b1) begin n_fail++; $display("FAIL flush_keeps_flag underrun=%b expected 1", underrun); end
  endtask

  task automatic test_async_reset();
    do_reset();
    enable = 1'b1; s_valid = 1'b1; s_data = 8'h5A;
    clk_n(1);
    s_data = 8'h6B;
    clk_n(1);
    s_valid = 1'b0;
    clk_n(3);
    n_checks++; if (dac_code !== 8'h5A) begin n_fail++; $display("FAIL arst_pre dac_code=%h expected 5a", dac_code); end
    #3;
    reset = 1'b1;
    #1;
    n_checks++; if (dac_code !== IDLE || playing !== 1'b0) begin n_fail++; $display("FAIL arst_out dac_code=%h playing=%b expected %h 0", dac_code, playing, IDLE); end
    n_checks++; if (fifo_level !== 3'd0 || s_ready !== 1'b1) begin n_fail++; $display("FAIL arst_fifo fifo_level=%0d s_ready=%b expected 0 1", fifo_level, s_ready); end
    clk_n(1);
    s_valid = 1'b1; s_data = 8'h77;
    reset = 1'b0;
    clk_n(1);
    s_data = 8'h88;
    clk_n(1);
    s_valid = 1'b0;
    clk_n(1);
    n_checks++; if (dac_code !== IDLE || playing !== 1'b1) begin n_fail++; $display("FAIL arst_edge3 dac_code=%h playing=%b expected %h 1", dac_code, playing, IDLE); end
    clk_n(1);
    n_checks++; if (dac_code !== 8'h77) begin n_fail++; $display("FAIL arst_first_tick dac_code=%h expected 77", dac_code); end
  endtask

  task automatic test_random();
    int fails_here;
    fails_here = 0;
    do_reset();
    m_q.delete(); m_mode = 0; m_dac = IDLE; m_under = 1'b0; m_edges = 0;
    for (int i = 0; i < 1500; i++) begin
      enable         = ($urandom_range(0, 24) != 0);
      s_valid        = ((i / 150) % 2 == 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 7) == 0);
      s_data         = 8'($urandom);
      flush          = ($urandom_range(0, 49) == 0);
      clear_underrun = ($urandom_range(0, 15) == 0);
      model_step();
      clk_n(1);
      n_checks++;
      if (dac_code !== m_dac || playing !== (m_mode == 2) || underrun !== m_under ||
          fifo_level !== 3'(m_q.size()) || s_ready !== (m_q.size() < FIFO_DEPTH)) begin
        n_fail++;
        fails_here++;
        if (fails_here <= 10)
          $display("FAIL random cycle %0d: dac=%h play=%b ur=%b lvl=%0d rdy=%b expected dac=%h play=%b ur=%b lvl=%0d rdy=%b",
                   i, dac_code, playing, underrun, fifo_level, s_ready,
                   m_dac, (m_mode == 2), m_under, m_q.size(), (m_q.size() < FIFO_DEPTH));
      end
    end
    enable = 1'b0; s_valid = 1'b0; flush = 1'b0; clear_underrun = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_fifo();
    test_underrun();
    test_disable();
    test_flush();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
